// File: rtl/reg_bus_master_pkg.sv
// Shared constants for the register-bus initiator: default command opcodes
// and the state encoding of the command parser.
package reg_bus_master_pkg;

    localparam logic [7:0] DEF_RD_OPCODE = 8'h80;
    localparam logic [7:0] DEF_WR_OPCODE = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        WDATA,
        RD_ISSUE,
        RD_WAIT
    } state_t;

endpackage

// File: rtl/reg_bus_master.sv
// Byte-stream command channel to register-bus initiator. Commands are
// header, address, length N and (for writes) N data bytes; reads stream N bytes on tx.
module reg_bus_master
    import reg_bus_master_pkg::*;
#(
    parameter int         pBYTECNT_SIZE = 7,
    parameter logic [7:0] pRD_OPCODE    = DEF_RD_OPCODE,
    parameter logic [7:0] pWR_OPCODE    = DEF_WR_OPCODE
) (
    input  logic                     usb_clk,
    input  logic                     reset_n,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [7:0]               reg_address,
    output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
    output logic [7:0]               write_data,
    input  logic [7:0]               read_data,
    output logic                     reg_read,
    output logic                     reg_write,
    output logic                     reg_addrvalid,
    output logic                     busy,
    output logic                     cmd_error
);

    localparam logic [7:0] MAX_LEN8 = 8'((1 << pBYTECNT_SIZE) - 1);
    localparam logic [pBYTECNT_SIZE-1:0] CNT_ONE = {{(pBYTECNT_SIZE-1){1'b0}}, 1'b1};

    state_t                   state, state_d;
    logic                     is_read, is_read_d;
    logic [pBYTECNT_SIZE-1:0] len, len_d;
    logic [pBYTECNT_SIZE-1:0] rx_cnt, rx_cnt_d;
    logic [pBYTECNT_SIZE-1:0] len_sat;
    logic [pBYTECNT_SIZE-1:0] reg_bytecnt_d;
    logic [7:0]               reg_address_d, write_data_d, tx_data_d;
    logic                     reg_addrvalid_d, reg_write_d, reg_read_d;
    logic                     tx_valid_d, cmd_error_d;
    logic                     accept, rx_hs, last_byte;

    // Lengths beyond what reg_bytecnt can index are clamped so the counter never wraps.
    assign len_sat   = (rx_data > MAX_LEN8) ? '1 : rx_data[pBYTECNT_SIZE-1:0];
    assign last_byte = (reg_bytecnt == (len - CNT_ONE));

    // In WDATA, stop accepting once all N data bytes are in; only the final strobe remains.
    always_comb begin
        accept = 1'b0;
        case (state)
            IDLE, ADDR, LEN: accept = 1'b1;
            WDATA:           accept = (rx_cnt != len);
            default:         accept = 1'b0;
        endcase
    end

    assign rx_ready = reset_n & accept;
    assign rx_hs    = rx_valid & accept;
    assign busy     = (state != IDLE);

    always_comb begin
        state_d         = state;
        is_read_d       = is_read;
        len_d           = len;
        rx_cnt_d        = rx_cnt;
        reg_address_d   = reg_address;
        reg_addrvalid_d = reg_addrvalid;
        reg_bytecnt_d   = reg_bytecnt;
        write_data_d    = write_data;
        tx_data_d       = tx_data;
        tx_valid_d      = tx_valid;
        reg_write_d     = 1'b0;
        reg_read_d      = 1'b0;
        cmd_error_d     = 1'b0;

        case (state)
            IDLE: begin
                if (rx_hs) begin
                    if (rx_data == pWR_OPCODE) begin
                        is_read_d = 1'b0;
                        state_d   = ADDR;
                    end else if (rx_data == pRD_OPCODE) begin
                        is_read_d = 1'b1;
                        state_d   = ADDR;
                    end else begin
                        cmd_error_d = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (rx_hs) begin
                    reg_address_d   = rx_data;
                    reg_addrvalid_d = 1'b1;
                    state_d         = LEN;
                end
            end
            LEN: begin
                if (rx_hs) begin
                    len_d         = len_sat;
                    rx_cnt_d      = '0;
                    reg_bytecnt_d = '0;
                    if (len_sat == '0) begin
                        reg_addrvalid_d = 1'b0;
                        state_d         = IDLE;
                    end else if (is_read) begin
                        reg_read_d = 1'b1;
                        state_d    = RD_ISSUE;
                    end else begin
                        state_d = WDATA;
                    end
                end
            end
            WDATA: begin
                if (reg_write) begin
                    reg_bytecnt_d = reg_bytecnt + CNT_ONE;
                    if (last_byte) begin
                        reg_addrvalid_d = 1'b0;
                        state_d         = IDLE;
                    end
                end
                if (rx_hs) begin
                    reg_write_d  = 1'b1;
                    write_data_d = rx_data;
                    rx_cnt_d     = rx_cnt + CNT_ONE;
                end
            end
            // The read strobe is high for this single cycle; the tx slot is always empty here.
            RD_ISSUE: begin
                tx_data_d  = read_data;
                tx_valid_d = 1'b1;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    if (last_byte) begin
                        reg_addrvalid_d = 1'b0;
                        state_d         = IDLE;
                    end else begin
                        reg_bytecnt_d = reg_bytecnt + CNT_ONE;
                        reg_read_d    = 1'b1;
                        state_d       = RD_ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            is_read       <= 1'b0;
            len           <= '0;
            rx_cnt        <= '0;
            reg_address   <= '0;
            reg_addrvalid <= 1'b0;
            reg_bytecnt   <= '0;
            write_data    <= '0;
            tx_data       <= '0;
            tx_valid      <= 1'b0;
            reg_write     <= 1'b0;
            reg_read      <= 1'b0;
            cmd_error     <= 1'b0;
        end else begin
            state         <= state_d;
            is_read       <= is_read_d;
            len           <= len_d;
            rx_cnt        <= rx_cnt_d;
            reg_address   <= reg_address_d;
            reg_addrvalid <= reg_addrvalid_d;
            reg_bytecnt   <= reg_bytecnt_d;
            write_data    <= write_data_d;
            tx_data       <= tx_data_d;
            tx_valid      <= tx_valid_d;
            reg_write     <= reg_write_d;
            reg_read      <= reg_read_d;
            cmd_error     <= cmd_error_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: command vectors against a register-array
// responder, plus hand sequences for backpressure, reset mid-burst and length clamping.
module tb_reg_bus_master;

    localparam int W = 7;

    logic         usb_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic [7:0]   reg_address;
    logic [W-1:0] reg_bytecnt;
    logic [7:0]   write_data;
    logic [7:0]   read_data;
    logic         reg_read;
    logic         reg_write;
    logic         reg_addrvalid;
    logic         busy;
    logic         cmd_error;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 usb_clk = ~usb_clk;

    reg_bus_master #(
        .pBYTECNT_SIZE(W),
        .pRD_OPCODE   (8'h80),
        .pWR_OPCODE   (8'h00)
    ) dut (
        .usb_clk      (usb_clk),
        .reset_n      (reset_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .reg_address  (reg_address),
        .reg_bytecnt  (reg_bytecnt),
        .write_data   (write_data),
        .read_data    (read_data),
        .reg_read     (reg_read),
        .reg_write    (reg_write),
        .reg_addrvalid(reg_addrvalid),
        .busy         (busy),
        .cmd_error    (cmd_error)
    );

    // Responder: 256-byte register array, preset to i*3+1, indexed by address+bytecnt.
    logic [7:0] resp_mem [256];
    bit         mem_inited = 1'b0;

    assign read_data = resp_mem[reg_address + 8'(reg_bytecnt)];

    always @(posedge usb_clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) resp_mem[i] <= 8'(i * 3 + 1);
            mem_inited <= 1'b1;
        end else if (reg_write) begin
            resp_mem[reg_address + 8'(reg_bytecnt)] <= write_data;
        end
    end

    int         cyc = 0;
    int         err_cycles = 0;
    int         viol_cnt = 0;
    int         hold_err = 0;
    int         av_fall_cyc = 0;
    logic       prev_hold = 1'b0;
    logic       prev_av = 1'b0;
    logic [7:0] prev_tx = 8'h00;
    logic [7:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    logic [W-1:0] wr_cnt_q [$];
    int         wr_cyc_q [$];
    int         rd_cyc_q [$];
    logic [7:0] tx_q [$];

    // Bus observer on the falling edge, away from the edge the DUT updates on.
    always @(negedge usb_clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            prev_hold <= 1'b0;
            prev_av   <= 1'b0;
        end else begin
            if (reg_write) begin
                wr_addr_q.push_back(reg_address);
                wr_data_q.push_back(write_data);
                wr_cnt_q.push_back(reg_bytecnt);
                wr_cyc_q.push_back(cyc);
            end
            if (reg_read) rd_cyc_q.push_back(cyc);
            if ((reg_read && reg_write) || ((reg_read || reg_write) && !reg_addrvalid))
                viol_cnt <= viol_cnt + 1;
            if (tx_valid && tx_ready) tx_q.push_back(tx_data);
            if (prev_hold && (!tx_valid || tx_data != prev_tx)) hold_err <= hold_err + 1;
            prev_hold <= tx_valid && !tx_ready;
            prev_tx   <= tx_data;
            if (cmd_error) err_cycles <= err_cycles + 1;
            if (prev_av && !reg_addrvalid) av_fall_cyc <= cyc;
            prev_av <= reg_addrvalid;
        end
    end

    typedef struct {
        logic [7:0]      hdr;
        logic [7:0]      addr;
        logic [7:0]      n;
        logic [3:0][7:0] d;
        int              exp_wr;
        int              exp_tx;
        int              exp_err;
        bit              chk_gap;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] hdr, input logic [7:0] addr,
                                input logic [7:0] n, input logic [3:0][7:0] d,
                                input int exp_wr, input int exp_tx, input int exp_err,
                                input bit chk_gap);
        vec_t v;
        v.hdr = hdr; v.addr = addr; v.n = n; v.d = d;
        v.exp_wr = exp_wr; v.exp_tx = exp_tx; v.exp_err = exp_err; v.chk_gap = chk_gap;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 300) begin
            @(posedge usb_clk); #1;
            t++;
        end
        if (t >= 300) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL rx handshake timeout: got no rx_ready, expected rx_ready=1");
        end
        @(posedge usb_clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int t = 0;
        while ((busy || reg_addrvalid || tx_valid || reg_write || reg_read) && t < 400) begin
            @(posedge usb_clk); #1;
            t++;
        end
        if (t >= 400) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL idle timeout: got busy=%0b, expected 0", busy);
        end
        repeat (2) begin @(posedge usb_clk); #1; end
    endtask

    task automatic applyStimulus(input vec_t v);
        sendByte(v.hdr);
        if (v.hdr == 8'h00 || v.hdr == 8'h80) begin
            sendByte(v.addr);
            sendByte(v.n);
            if (v.hdr == 8'h00)
                for (int i = 0; i < int'(v.n) && i < 4; i++) sendByte(v.d[i]);
        end
        waitIdle();
    endtask

    task automatic runVector(input vec_t v, input string name);
        int wb = wr_data_q.size();
        int rb = rd_cyc_q.size();
        int tb0 = tx_q.size();
        int e0 = err_cycles;
        int vi0 = viol_cnt;
        int h0 = hold_err;
        applyStimulus(v);
        checkOutput({name, " write strobes"}, 32'(wr_data_q.size() - wb), 32'(v.exp_wr));
        for (int i = 0; i < v.exp_wr && wb + i < wr_data_q.size(); i++) begin
            checkOutput($sformatf("%s wr addr[%0d]", name, i), 32'(wr_addr_q[wb + i]), 32'(v.addr));
            checkOutput($sformatf("%s wr bytecnt[%0d]", name, i), 32'(wr_cnt_q[wb + i]), 32'(i));
            checkOutput($sformatf("%s wr data[%0d]", name, i), 32'(wr_data_q[wb + i]), 32'(v.d[i]));
        end
        if (v.exp_wr > 0 && wr_cyc_q.size() > wb)
            checkOutput({name, " addrvalid drop gap"},
                        32'(av_fall_cyc - wr_cyc_q[wr_cyc_q.size() - 1]), 32'd1);
        checkOutput({name, " read strobes"}, 32'(rd_cyc_q.size() - rb), 32'(v.exp_tx));
        checkOutput({name, " tx bytes"}, 32'(tx_q.size() - tb0), 32'(v.exp_tx));
        for (int i = 0; i < v.exp_tx && tb0 + i < tx_q.size(); i++)
            checkOutput($sformatf("%s tx[%0d]", name, i), 32'(tx_q[tb0 + i]), 32'(v.d[i]));
        if (v.chk_gap)
            for (int i = rb; i + 1 < rd_cyc_q.size(); i++)
                checkOutput($sformatf("%s read gap %0d", name, i - rb),
                            32'(rd_cyc_q[i + 1] - rd_cyc_q[i]), 32'd2);
        checkOutput({name, " cmd_error cycles"}, 32'(err_cycles - e0), 32'(v.exp_err));
        checkOutput({name, " strobe overlap"}, 32'(viol_cnt - vi0), 32'd0);
        checkOutput({name, " tx hold"}, 32'(hold_err - h0), 32'd0);
        checkOutput({name, " busy after"}, 32'(busy), 32'd0);
    endtask

    vec_t table_v [7];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       v;
        int         rb, tb0, h0, t, seen, wb;
        logic [3:0][7:0] rd;

        table_v[0] = mk(8'h00, 8'h05, 8'd3, {8'h00, 8'h33, 8'h22, 8'h11}, 3, 0, 0, 1'b0);
        table_v[1] = mk(8'h42, 8'h00, 8'd0, 32'h0, 0, 0, 1, 1'b0);
        table_v[2] = mk(8'h80, 8'h05, 8'd3, {8'h00, 8'h33, 8'h22, 8'h11}, 0, 3, 0, 1'b1);
        table_v[3] = mk(8'h00, 8'h40, 8'd0, 32'h0, 0, 0, 0, 1'b0);
        table_v[4] = mk(8'h00, 8'h10, 8'd2, {8'h00, 8'h00, 8'h5A, 8'hA5}, 2, 0, 0, 1'b0);
        table_v[5] = mk(8'h80, 8'h10, 8'd2, {8'h00, 8'h00, 8'h5A, 8'hA5}, 0, 2, 0, 1'b1);
        table_v[6] = mk(8'h80, 8'h08, 8'd1, {8'h00, 8'h00, 8'h00, 8'h19}, 0, 1, 0, 1'b0);

        repeat (3) @(posedge usb_clk);
        #1;
        checkOutput("reset flags", 32'({reg_read, reg_write, tx_valid, reg_addrvalid,
                                        busy, rx_ready, cmd_error}), 32'd0);
        checkOutput("reset data", 32'({tx_data, reg_address, write_data}), 32'd0);
        checkOutput("reset bytecnt", 32'(reg_bytecnt), 32'd0);
        @(negedge usb_clk);
        reset_n = 1'b1;
        @(posedge usb_clk); #1;
        checkOutput("rx_ready after reset", 32'(rx_ready), 32'd1);

        for (int k = 0; k < 7; k++) runVector(table_v[k], $sformatf("vec%0d", k));

        // 8-byte read at 0x20 from preset contents; tx_ready held high.
        rb = rd_cyc_q.size();
        tb0 = tx_q.size();
        sendByte(8'h80); sendByte(8'h20); sendByte(8'd8);
        waitIdle();
        checkOutput("rd8 tx bytes", 32'(tx_q.size() - tb0), 32'd8);
        for (int i = 0; i < 8 && tb0 + i < tx_q.size(); i++)
            checkOutput($sformatf("rd8 tx[%0d]", i), 32'(tx_q[tb0 + i]), 32'(8'((8'h20 + i) * 3 + 1)));
        checkOutput("rd8 read strobes", 32'(rd_cyc_q.size() - rb), 32'd8);
        for (int i = rb; i + 1 < rd_cyc_q.size(); i++)
            checkOutput($sformatf("rd8 gap %0d", i - rb), 32'(rd_cyc_q[i + 1] - rd_cyc_q[i]), 32'd2);

        // Backpressure: first response byte held for 10 cycles.
        tx_ready = 1'b0;
        rb = rd_cyc_q.size();
        tb0 = tx_q.size();
        h0 = hold_err;
        sendByte(8'h80); sendByte(8'h30); sendByte(8'd4);
        t = 0;
        while (!tx_valid && t < 20) begin @(posedge usb_clk); #1; t++; end
        checkOutput("bp first tx_valid", 32'(tx_valid), 32'd1);
        repeat (10) begin @(posedge usb_clk); #1; end
        checkOutput("bp held tx_valid", 32'(tx_valid), 32'd1);
        checkOutput("bp held tx_data", 32'(tx_data), 32'h91);
        checkOutput("bp reads while held", 32'(rd_cyc_q.size() - rb), 32'd1);
        tx_ready = 1'b1;
        waitIdle();
        checkOutput("bp tx bytes", 32'(tx_q.size() - tb0), 32'd4);
        for (int i = 0; i < 4 && tb0 + i < tx_q.size(); i++)
            checkOutput($sformatf("bp tx[%0d]", i), 32'(tx_q[tb0 + i]), 32'(8'((8'h30 + i) * 3 + 1)));
        checkOutput("bp hold violations", 32'(hold_err - h0), 32'd0);
        checkOutput("bp read strobes", 32'(rd_cyc_q.size() - rb), 32'd4);

        // Reset asserted during the second read strobe of a 4-byte read.
        sendByte(8'h80); sendByte(8'h50); sendByte(8'd4);
        seen = 0;
        t = 0;
        while (seen < 2 && t < 40) begin
            if (reg_read) seen++;
            if (seen < 2) begin @(posedge usb_clk); #1; t++; end
        end
        checkOutput("rst second strobe seen", 32'(seen), 32'd2);
        reset_n = 1'b0;
        #1;
        checkOutput("rst mid flags", 32'({reg_read, reg_write, tx_valid, reg_addrvalid,
                                          busy, rx_ready, cmd_error}), 32'd0);
        checkOutput("rst mid data", 32'({tx_data, reg_address, write_data}), 32'd0);
        checkOutput("rst mid bytecnt", 32'(reg_bytecnt), 32'd0);
        repeat (2) @(posedge usb_clk);
        @(negedge usb_clk);
        reset_n = 1'b1;
        @(posedge usb_clk); #1;
        runVector(mk(8'h00, 8'h60, 8'd2, {8'h00, 8'h00, 8'h3C, 8'hC3}, 2, 0, 0, 1'b0), "post-rst wr");
        runVector(mk(8'h80, 8'h60, 8'd2, {8'h00, 8'h00, 8'h3C, 8'hC3}, 0, 2, 0, 1'b1), "post-rst rd");

        // Mixed random write/read-back bursts.
        for (int k = 0; k < 6; k++) begin
            logic [7:0] a;
            logic [7:0] n;
            a = 8'($urandom_range(8'h80, 8'hF0));
            n = 8'($urandom_range(1, 4));
            for (int i = 0; i < 4; i++) rd[i] = 8'($urandom);
            v = mk(8'h00, a, n, rd, int'(n), 0, 0, 1'b0);
            runVector(v, $sformatf("rnd%0d wr", k));
            v = mk(8'h80, a, n, rd, 0, int'(n), 0, 1'b1);
            runVector(v, $sformatf("rnd%0d rd", k));
        end

        // Oversized length clamps to 127 bytes.
        wb = wr_data_q.size();
        sendByte(8'h00); sendByte(8'h00); sendByte(8'hFF);
        for (int i = 0; i < 127; i++) sendByte(8'(i + 1));
        waitIdle();
        checkOutput("sat write strobes", 32'(wr_data_q.size() - wb), 32'd127);
        if (wr_data_q.size() > wb) begin
            checkOutput("sat last bytecnt", 32'(wr_cnt_q[wr_cnt_q.size() - 1]), 32'd126);
            checkOutput("sat last data", 32'(wr_data_q[wr_data_q.size() - 1]), 32'd127);
        end
        checkOutput("sat rx_ready idle", 32'(rx_ready), 32'd1);
        runVector(mk(8'h80, 8'h00, 8'd2, {8'h00, 8'h00, 8'h02, 8'h01}, 0, 2, 0, 1'b1), "sat rd");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
